// File: rtl/memory_fill_engine_if.sv
// Command, status and memory-write bus of the fill engine.
// The slave modport is the engine; the master modport is the host/memory side.
interface memory_fill_engine_if #(
    parameter int ADDR_WIDTH = 17,
    parameter int DATA_WIDTH = 8
);
    logic                  start;
    logic [ADDR_WIDTH-1:0] startAddress;
    logic [ADDR_WIDTH-1:0] length;
    logic [DATA_WIDTH-1:0] fillValue;
    logic                  fillIncrement;
    logic                  abort;
    logic                  busy;
    logic                  done;
    logic [ADDR_WIDTH-1:0] memoryAddress;
    logic [DATA_WIDTH-1:0] memoryWriteData;
    logic                  memoryWriteRequest;
    logic                  memoryWriteComplete;

    modport master (
        output start, startAddress, length, fillValue, fillIncrement, abort,
        output memoryWriteComplete,
        input  busy, done, memoryAddress, memoryWriteData, memoryWriteRequest
    );

    modport slave (
        input  start, startAddress, length, fillValue, fillIncrement, abort,
        input  memoryWriteComplete,
        output busy, done, memoryAddress, memoryWriteData, memoryWriteRequest
    );
endinterface

// File: rtl/memory_fill_engine.sv
// Fills a range of video RAM with a constant or incrementing byte pattern,
// one request/complete handshake per byte; every output comes from a register.
module memory_fill_engine #(
    parameter int ADDR_WIDTH = 17,
    parameter int DATA_WIDTH = 8
) (
    input  logic                 clock,
    input  logic                 resetN,
    memory_fill_engine_if.slave  bus
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        GAP   = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t                state_reg, state_next;
    logic [ADDR_WIDTH-1:0] addr_reg, addr_next;
    logic [ADDR_WIDTH-1:0] remaining_reg, remaining_next;
    logic [DATA_WIDTH-1:0] data_reg, data_next;
    logic                  inc_reg, inc_next;
    logic                  busy_reg, busy_next;
    logic                  done_reg, done_next;
    logic                  req_reg, req_next;

    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            state_reg     <= IDLE;
            addr_reg      <= '0;
            remaining_reg <= '0;
            data_reg      <= '0;
            inc_reg       <= 1'b0;
            busy_reg      <= 1'b0;
            done_reg      <= 1'b0;
            req_reg       <= 1'b0;
        end else begin
            state_reg     <= state_next;
            addr_reg      <= addr_next;
            remaining_reg <= remaining_next;
            data_reg      <= data_next;
            inc_reg       <= inc_next;
            busy_reg      <= busy_next;
            done_reg      <= done_next;
            req_reg       <= req_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        addr_next      = addr_reg;
        remaining_next = remaining_reg;
        data_next      = data_reg;
        inc_next       = inc_reg;
        busy_next      = busy_reg;
        done_next      = 1'b0;
        req_next       = req_reg;

        case (state_reg)
            IDLE: begin
                if (bus.start) begin
                    busy_next = 1'b1;
                    if (bus.length != '0) begin
                        addr_next      = bus.startAddress;
                        data_next      = bus.fillValue;
                        inc_next       = bus.fillIncrement;
                        remaining_next = bus.length;
                        req_next       = 1'b1;
                        state_next     = WRITE;
                    end else begin
                        // Zero-length command: pass through GAP with nothing
                        // left so busy shows for one cycle and no write occurs.
                        remaining_next = '0;
                        state_next     = GAP;
                    end
                end
            end

            WRITE: begin
                if (bus.memoryWriteComplete) begin
                    req_next       = 1'b0;
                    remaining_next = remaining_reg - ADDR_WIDTH'(1);
                    addr_next      = addr_reg + ADDR_WIDTH'(1);
                    if (inc_reg) begin
                        data_next = data_reg + DATA_WIDTH'(1);
                    end
                    state_next = GAP;
                end
            end

            GAP: begin
                if ((remaining_reg == '0) || bus.abort) begin
                    done_next  = 1'b1;
                    busy_next  = 1'b0;
                    state_next = DONE;
                end else begin
                    req_next   = 1'b1;
                    state_next = WRITE;
                end
            end

            DONE: begin
                state_next = IDLE;
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign bus.busy               = busy_reg;
    assign bus.done               = done_reg;
    assign bus.memoryAddress      = addr_reg;
    assign bus.memoryWriteData    = data_reg;
    assign bus.memoryWriteRequest = req_reg;
endmodule

// File: tb/tb_memory_fill_engine.sv
// Directed and randomized fill commands compared against a list of expected
// (address, byte) writes computed with plain modular arithmetic.
module tb_memory_fill_engine;
    localparam int AW = 17;
    localparam int DW = 8;

    logic clock  = 1'b0;
    logic resetN = 1'b0;
    always #5 clock = ~clock;

    memory_fill_engine_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    memory_fill_engine #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clock  (clock),
        .resetN (resetN),
        .bus    (bus)
    );

    int checks   = 0;
    int failures = 0;

    // Memory responder: request held resp_delay+1 cycles before complete is sampled.
    int resp_delay = 1;
    int hold_cnt   = 0;
    always @(negedge clock) begin
        if (!resetN || !bus.memoryWriteRequest) begin
            hold_cnt = 0;
            bus.memoryWriteComplete = 1'b0;
        end else begin
            hold_cnt++;
            bus.memoryWriteComplete = (hold_cnt > resp_delay);
        end
    end

    // Write monitor: records each completed handshake and request behaviour.
    logic [AW+DW-1:0] obs_q[$];
    int req_rises  = 0;
    int cur_hold   = 0;
    int last_hold  = 0;
    int stable_err = 0;
    logic [AW-1:0] held_addr = '0;
    logic [DW-1:0] held_data = '0;
    logic prev_req = 1'b0;
    always @(posedge clock) begin
        if (resetN && bus.memoryWriteRequest) begin
            if (!prev_req) begin
                req_rises++;
                held_addr = bus.memoryAddress;
                held_data = bus.memoryWriteData;
                cur_hold  = 0;
            end else if (bus.memoryAddress !== held_addr || bus.memoryWriteData !== held_data) begin
                stable_err++;
            end
            cur_hold++;
            if (bus.memoryWriteComplete) begin
                obs_q.push_back({bus.memoryAddress, bus.memoryWriteData});
                last_hold = cur_hold;
            end
        end
        prev_req = resetN && bus.memoryWriteRequest;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Issue one command (caller is 1 time unit after a rising edge) and check it.
    task automatic run_cmd(input string tag, input logic [AW-1:0] sa, input logic [AW-1:0] len,
                           input logic [DW-1:0] fv, input logic inc, input int dly,
                           input int abort_after, input bit restart, output int cyc);
        int base, rises0, n_exp, n_obs;
        logic [AW-1:0] ea;
        logic [DW-1:0] ed;
        resp_delay = dly;
        base   = obs_q.size();
        rises0 = req_rises;
        n_exp  = (abort_after >= 0 && abort_after < int'(len)) ? abort_after : int'(len);
        bus.start = 1'b1; bus.startAddress = sa; bus.length = len;
        bus.fillValue = fv; bus.fillIncrement = inc;
        @(posedge clock); #1;
        bus.start = 1'b0;
        chk({tag, "/busy_after_start"}, 32'(bus.busy), 32'd1);
        cyc = 0;
        while (!bus.done && cyc < 2000) begin
            if (abort_after >= 0 && (obs_q.size() - base) == abort_after - 1 && bus.memoryWriteRequest)
                bus.abort = 1'b1;
            if (restart && cyc == 2) begin
                bus.start = 1'b1; bus.startAddress = sa + AW'(100);
                bus.length = AW'(7); bus.fillValue = ~fv; bus.fillIncrement = ~inc;
            end else begin
                bus.start = 1'b0;
            end
            @(posedge clock); #1;
            cyc++;
        end
        bus.start = 1'b0;
        chk({tag, "/done_seen"}, 32'(bus.done), 32'd1);
        chk({tag, "/busy_at_done"}, 32'(bus.busy), 32'd0);
        @(posedge clock); #1;
        bus.abort = 1'b0;
        chk({tag, "/done_one_cycle"}, 32'(bus.done), 32'd0);
        n_obs = obs_q.size() - base;
        chk({tag, "/write_count"}, 32'(n_obs), 32'(n_exp));
        chk({tag, "/request_count"}, 32'(req_rises - rises0), 32'(n_exp));
        for (int i = 0; i < n_exp && i < n_obs; i++) begin
            ea = sa + AW'(i);
            ed = inc ? fv + DW'(i) : fv;
            chk($sformatf("%s/write%0d", tag, i), 32'(obs_q[base + i]), 32'({ea, ed}));
        end
        $display("cmd %s addr=%05h len=%0d val=%02h inc=%0d writes=%0d cycles=%0d",
                 tag, sa, len, fv, inc, n_obs, cyc);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        logic [AW-1:0] ra;
        bus.start = 1'b0; bus.startAddress = '0; bus.length = '0;
        bus.fillValue = '0; bus.fillIncrement = 1'b0; bus.abort = 1'b0;

        repeat (2) @(posedge clock);
        #1;
        chk("reset/busy", 32'(bus.busy), 32'd0);
        chk("reset/done", 32'(bus.done), 32'd0);
        chk("reset/request", 32'(bus.memoryWriteRequest), 32'd0);
        chk("reset/addr", 32'(bus.memoryAddress), 32'd0);
        chk("reset/data", 32'(bus.memoryWriteData), 32'd0);

        // Start presented together with reset release: taken on the first edge.
        resetN = 1'b1;
        run_cmd("const3", AW'('h00100), AW'(3), 8'hAA, 1'b0, 1, -1, 1'b0, cyc);
        chk("const3/cycles", 32'(cyc), 32'd9);
        chk("const3/busy_after", 32'(bus.busy), 32'd0);

        run_cmd("wrap3", AW'('h1FFFE), AW'(3), 8'hFE, 1'b1, 1, -1, 1'b0, cyc);

        run_cmd("len0", AW'('h00042), AW'(0), 8'h55, 1'b0, 1, -1, 1'b0, cyc);
        chk("len0/cycles", 32'(cyc), 32'd1);

        run_cmd("abort", AW'('h00200), AW'(10), 8'h10, 1'b1, 4, 4, 1'b0, cyc);
        chk("abort/request_hold", 32'(last_hold), 32'd5);

        // Asynchronous reset in the middle of a write.
        resp_delay = 3;
        bus.start = 1'b1; bus.startAddress = AW'('h00300); bus.length = AW'(10);
        bus.fillValue = 8'h77; bus.fillIncrement = 1'b1;
        @(posedge clock); #1;
        bus.start = 1'b0;
        chk("rst/request_before", 32'(bus.memoryWriteRequest), 32'd1);
        #2 resetN = 1'b0;
        #1;
        chk("rst/request", 32'(bus.memoryWriteRequest), 32'd0);
        chk("rst/busy", 32'(bus.busy), 32'd0);
        chk("rst/addr", 32'(bus.memoryAddress), 32'd0);
        chk("rst/data", 32'(bus.memoryWriteData), 32'd0);
        @(posedge clock); #1;
        resetN = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        chk("rst/no_resume", 32'(bus.memoryWriteRequest | bus.busy), 32'd0);
        run_cmd("restart", AW'('h00400), AW'(2), 8'h33, 1'b1, 1, -1, 1'b1, cyc);

        for (int k = 0; k < 6; k++) begin
            ra = (k % 2 == 1) ? AW'('h1FFFF) - AW'($urandom_range(0, 3)) : AW'($urandom_range(0, 'h1FFFF));
            run_cmd($sformatf("rand%0d", k), ra, AW'($urandom_range(1, 6)), DW'($urandom),
                    1'($urandom_range(0, 1)), int'($urandom_range(0, 3)), -1, 1'b0, cyc);
        end

        chk("addr_data_stable", 32'(stable_err), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
